song_sequencer: RTL
===================

Name: song_sequencer

Overview:
- Auto-play controller for the buzzer tone generator.
- Walks a song ROM entry by entry and drives the buzzer's `note` and `octave_auto` inputs.
- Times each note in beat units and inserts a short silent gap between notes.
- Supports play, pause, stop, and song select. Sits between the user-input/mode logic and the buzzer; active when the top-level mode selects auto-play.

Parameters:
- BEAT_TICKS, 12_500_000, clk cycles per beat unit (1/8 s at 100 MHz)
- GAP_TICKS, 1_000_000, clk cycles of silence between consecutive notes
- IDX_W, 6, song index width; max 2^IDX_W entries per song

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- play  in  1  one-cycle pulse: start from IDLE, or resume from PAUSED
- pause  in  1  one-cycle pulse: toggle pause while busy
- stop  in  1  one-cycle pulse: abort to IDLE
- song_sel  in  2  song number, latched on start
- loop  in  1  repeat song at end (used only with LOOP_EN)
- rom_addr  out  2+IDX_W  {song_sel_latched, index}
- rom_data  in  10  {note[9:6], octave[5:4], dur[3:0]}, valid 1 cycle after rom_addr
- note  out  4  to buzzer; 0 = silent, 1..7 = do..si
- octave_auto  out  2  to buzzer; 01 higher, 10 lower, 00/11 standard
- busy  out  1  high in every state except IDLE
- paused  out  1  high in PAUSED
- done  out  1  one-cycle pulse at natural end of song
- index  out  IDX_W  current entry number

Behaviour:
- Reset (async) values: state IDLE, note 0, octave_auto 00, busy 0, paused 0, done 0, index 0, rom_addr 0. A reset mid-song returns to these values immediately.
- All outputs are registered.
- Input priority when pulses coincide: stop > pause > play.
- IDLE:
  - note 0.
  - play -> latch song_sel, index <= 0, go to FETCH.
  - pause and stop are ignored.
- FETCH: rom_addr = {sel, index}; go to LOAD on the next cycle.
- LOAD: rom_data is valid.
  - If dur == 0 (end marker) -> DONE.
  - Otherwise latch note and octave, set beats_left = dur, clear tick counter, go to PLAY.
  - note and octave_auto update on the same edge that enters PLAY.
- PLAY:
  - The tick counter counts 0..BEAT_TICKS-1. On wrap, beats_left decrements.
  - When the wrap occurs with beats_left == 1 -> GAP.
  - PLAY lasts exactly dur*BEAT_TICKS cycles.
  - A ROM note of 0 is a rest: same timing, note output 0.
- GAP:
  - note = 0 and octave_auto holds its value for exactly GAP_TICKS cycles.
  - If index == all-ones -> DONE. Otherwise index + 1 -> FETCH.
- DONE: done = 1 for one cycle, then IDLE with note 0. index holds its last value until the next start.
- Latency: play sampled at edge k -> FETCH after k, LOAD after k+1, first note on outputs after edge k+2.
- Pause:
  - pause in FETCH, LOAD, PLAY, or GAP -> PAUSED.
  - The return state and all counters are saved and frozen; note = 0.
  - pause or play in PAUSED -> return to the saved state with counters intact, so the remaining duration is preserved.
  - For the pause-to-return transition, FETCH/LOAD return to FETCH, which re-issues the address; the original LOAD data is stale.
  - In PLAY the sounding note reappears on the resume edge.
- Stop: from any busy state -> IDLE on the next edge, note 0, done not pulsed.
- play while busy and not paused is ignored. song_sel changes while busy are ignored.
- Counter widths are sized by $clog2 of their parameter. No counter wraps outside the rules above.

Optional Feature:
- Macro: SONG_SEQUENCER_LOOP_EN
- Defined: in DONE with loop == 1, done still pulses. The next state is FETCH with index 0 and the same latched song instead of IDLE; busy stays 1. With loop == 0 the behaviour is as without the macro.
- Undefined: the loop input is ignored; DONE always goes to IDLE.

Decomposition:
- Shared package song_pkg holds:
  - state encoding (IDLE, FETCH, LOAD, PLAY, GAP, PAUSED, DONE)
  - ROM word field positions and widths
  - END_DUR = 0
  - octave codes OCT_HIGH = 01, OCT_LOW = 10, OCT_STD = 00
  - note code NOTE_REST = 0
- One sub-module, beat_timer: tick counter plus beats_left. Inputs load, dur, enable; output finish strobe. Reused for GAP timing with dur = 1 and a separate terminal count.

Test Plan (BEAT_TICKS = 4, GAP_TICKS = 2, ROM song 0 = [(3,00,2),(5,01,1),(0,00,0)]):
- Reset then play pulse -> note = 3 two edges after play; holds 8 cycles; note 0 for 2 cycles; then note = 5 with octave_auto 01 for 4 cycles; 0 for 2; done pulses once; busy falls.
- Pause 3 cycles into note 3, hold 10 cycles, then play -> note 0 and paused = 1 during the hold; after resume, note 3 lasts exactly 5 more cycles.
- stop during the second note's GAP -> IDLE next cycle, note 0, busy 0, done never asserted.
- stop and pause in the same cycle during PLAY -> IDLE (stop wins). play while busy -> no effect on index or timing.
- Song of 64 non-zero entries -> after index 63's GAP, done pulses and index does not wrap to 0.
- SONG_SEQUENCER_LOOP_EN defined, loop = 1 -> after the end marker, done pulses and note = 3 reappears 2 cycles later with busy held high. Async rst mid-PLAY -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding, ROM word
// layout and the note/octave codes understood by the buzzer.
package song_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4,
        ST_PAUSED = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // ROM word: {note[9:6], octave[5:4], dur[3:0]}
    localparam int ROM_W    = 10;
    localparam int NOTE_W   = 4;
    localparam int OCT_W    = 2;
    localparam int DUR_W    = 4;
    localparam int NOTE_LSB = 6;
    localparam int OCT_LSB  = 4;
    localparam int DUR_LSB  = 0;

    localparam logic [DUR_W-1:0]  END_DUR   = 4'd0;
    localparam logic [OCT_W-1:0]  OCT_HIGH  = 2'b01;
    localparam logic [OCT_W-1:0]  OCT_LOW   = 2'b10;
    localparam logic [OCT_W-1:0]  OCT_STD   = 2'b00;
    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

    function automatic logic [NOTE_W-1:0] word_note(input logic [ROM_W-1:0] w);
        return w[NOTE_LSB +: NOTE_W];
    endfunction

    function automatic logic [OCT_W-1:0] word_oct(input logic [ROM_W-1:0] w);
        return w[OCT_LSB +: OCT_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [ROM_W-1:0] w);
        return w[DUR_LSB +: DUR_W];
    endfunction

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// Beat timer: a tick counter running 0..TICKS-1 and a beats-left counter that
// decrements on every tick wrap. finish_o strobes on the wrap of the last beat.
// Used both for note duration (dur beats) and for the inter-note gap (dur = 1).
module beat_timer
    import song_pkg::*;
#(
    parameter int TICKS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DUR_W-1:0] dur_i,
    input  logic             enable_i,
    output logic             finish_o
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(TICKS - 1);

    logic [CW-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0] beats_q, beats_d;
    logic             wrap_s;

    assign wrap_s   = (tick_q == LAST_TICK);
    assign finish_o = enable_i && !load_i && wrap_s && (beats_q == 4'd1);

    // Next-state for tick and beat counters: load wins, otherwise count when enabled.
    always_comb begin
        tick_d  = tick_q;
        beats_d = beats_q;
        if (load_i) begin
            tick_d  = '0;
            beats_d = dur_i;
        end else if (enable_i) begin
            if (wrap_s) begin
                tick_d  = '0;
                beats_d = beats_q - 4'd1;
            end else begin
                tick_d  = tick_q + CW'(1);
            end
        end else begin
            tick_d  = tick_q;
            beats_d = beats_q;
        end
    end

    // Counter registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q  <= '0;
            beats_q <= '0;
        end else begin
            tick_q  <= tick_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song ROM and drives the buzzer note/octave inputs,
// timing each note in beats with a silent gap between notes. Supports play,
// pause (toggle), stop and song select.
// Optional feature: define SONG_SEQUENCER_LOOP_EN to let the loop input
// restart the song from entry 0 at its natural end.
module song_sequencer
    import song_pkg::*;
#(
    parameter int BEAT_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 1_000_000,
    parameter int IDX_W      = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               play_i,
    input  logic               pause_i,
    input  logic               stop_i,
    input  logic [1:0]         song_sel_i,
    input  logic               loop_i,
    output logic [IDX_W+1:0]   rom_addr_o,
    input  logic [ROM_W-1:0]   rom_data_i,
    output logic [NOTE_W-1:0]  note_o,
    output logic [OCT_W-1:0]   octave_auto_o,
    output logic               busy_o,
    output logic               paused_o,
    output logic               done_o,
    output logic [IDX_W-1:0]   index_o
);

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    state_e             nxt_s;
    logic [1:0]         sel_q, sel_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [IDX_W-1:0]   idx_inc_s;
    logic [IDX_W+1:0]   rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [NOTE_W-1:0]  note_lat_q, note_lat_d;
    logic [OCT_W-1:0]   oct_q, oct_d;
    logic               busy_q, busy_d;
    logic               paused_q, paused_d;
    logic               done_q, done_d;

    logic [NOTE_W-1:0]  rom_note_s;
    logic [OCT_W-1:0]   rom_oct_s;
    logic [DUR_W-1:0]   rom_dur_s;
    logic               beat_load_s, beat_en_s, beat_fin_s;
    logic               gap_en_s, gap_fin_s;
    logic               last_s;

    assign rom_note_s  = word_note(rom_data_i);
    assign rom_oct_s   = word_oct(rom_data_i);
    assign rom_dur_s   = word_dur(rom_data_i);
    assign idx_inc_s   = index_q + IDX_W'(1);
    assign last_s      = &index_q;

    // Timers only run in their own state, so both freeze while paused.
    assign beat_load_s = (state_q == ST_LOAD) && !stop_i && !pause_i && (rom_dur_s != END_DUR);
    assign beat_en_s   = (state_q == ST_PLAY);
    assign gap_en_s    = (state_q == ST_GAP);

    beat_timer #(.TICKS(BEAT_TICKS)) u_beat (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (beat_load_s),
        .dur_i    (rom_dur_s),
        .enable_i (beat_en_s),
        .finish_o (beat_fin_s)
    );

    beat_timer #(.TICKS(GAP_TICKS)) u_gap (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (beat_fin_s),
        .dur_i    (4'd1),
        .enable_i (gap_en_s),
        .finish_o (gap_fin_s)
    );

`ifndef SONG_SEQUENCER_LOOP_EN
    logic unused_loop_s;
    assign unused_loop_s = loop_i;
`endif

    // Next-state and next-output logic; stop beats pause beats play.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        nxt_s      = state_q;
        sel_d      = sel_q;
        index_d    = index_q;
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        note_lat_d = note_lat_q;
        oct_d      = oct_q;

        case (state_q)
            ST_IDLE: begin
                note_d = NOTE_REST;
                if (play_i && !pause_i && !stop_i) begin
                    sel_d      = song_sel_i;
                    index_d    = '0;
                    rom_addr_d = {song_sel_i, {IDX_W{1'b0}}};
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_FETCH, ST_LOAD: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    note_d  = NOTE_REST;
                end else if (pause_i) begin
                    // LOAD data goes stale while paused, so resume re-fetches.
                    ret_d   = ST_FETCH;
                    state_d = ST_PAUSED;
                end else if (state_q == ST_FETCH) begin
                    state_d = ST_LOAD;
                end else if (rom_dur_s == END_DUR) begin
                    state_d = ST_DONE;
                end else begin
                    note_d     = rom_note_s;
                    note_lat_d = rom_note_s;
                    oct_d      = rom_oct_s;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    note_d  = NOTE_REST;
                end else begin
                    nxt_s = beat_fin_s ? ST_GAP : ST_PLAY;
                    if (beat_fin_s || pause_i) begin
                        note_d = NOTE_REST;
                    end else begin
                        note_d = note_q;
                    end
                    if (pause_i) begin
                        ret_d   = nxt_s;
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = nxt_s;
                    end
                end
            end
            ST_GAP: begin
                note_d = NOTE_REST;
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (gap_fin_s && last_s) begin
                    state_d = ST_DONE;
                end else begin
                    nxt_s = gap_fin_s ? ST_FETCH : ST_GAP;
                    if (gap_fin_s) begin
                        index_d    = idx_inc_s;
                        rom_addr_d = {sel_q, idx_inc_s};
                    end else begin
                        index_d    = index_q;
                    end
                    if (pause_i) begin
                        ret_d   = nxt_s;
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = nxt_s;
                    end
                end
            end
            ST_PAUSED: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    note_d  = NOTE_REST;
                end else if (pause_i || play_i) begin
                    state_d = ret_q;
                    // The held note sounds again on the resume edge.
                    note_d  = (ret_q == ST_PLAY) ? note_lat_q : NOTE_REST;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_DONE: begin
                note_d = NOTE_REST;
`ifdef SONG_SEQUENCER_LOOP_EN
                if (loop_i && !stop_i) begin
                    index_d    = '0;
                    rom_addr_d = {sel_q, {IDX_W{1'b0}}};
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                note_d  = NOTE_REST;
            end
        endcase

        busy_d   = (state_d != ST_IDLE);
        paused_d = (state_d == ST_PAUSED);
        done_d   = (state_d == ST_DONE);
    end

    // FSM state and all registered outputs, asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            sel_q      <= 2'd0;
            index_q    <= '0;
            rom_addr_q <= '0;
            note_q     <= NOTE_REST;
            note_lat_q <= NOTE_REST;
            oct_q      <= OCT_STD;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            sel_q      <= sel_d;
            index_q    <= index_d;
            rom_addr_q <= rom_addr_d;
            note_q     <= note_d;
            note_lat_q <= note_lat_d;
            oct_q      <= oct_d;
            busy_q     <= busy_d;
            paused_q   <= paused_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign note_o        = note_q;
    assign octave_auto_o = oct_q;
    assign busy_o        = busy_q;
    assign paused_o      = paused_q;
    assign done_o        = done_q;
    assign index_o       = index_q;

endmodule
